// File: rtl/serial_alu.sv
// Bit-serial ALU: latches WIDTH-bit operands and a mode, then computes one
// result bit per clock (LSB first) through a single slice, with flags on completion.
//
// state  | meaning
// S_IDLE | READY=1, waiting for START; accepts operands and mode
// S_RUN  | BUSY=1, one result bit per clock, LSB first
// S_DONE | DONE=1 for one cycle, output registers hold the new result

module serial_alu #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] X,
  output logic             C_out,
  output logic             ZERO,
  output logic             OVF,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [2:0] MODE_ADD  = 3'b000;
  localparam logic [2:0] MODE_AND  = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b011;
  localparam logic [2:0] MODE_XNOR = 3'b100;
  localparam logic [2:0] MODE_SUB  = 3'b101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, shift_q;
  logic [2:0]       mode_q;
  logic             carry_q;

  logic             accept, last_bit;
  logic             is_add, is_sub, is_arith, is_reserved;
  logic             a_bit, b_bit, sum_bit, carry_nx, r_bit;
  logic [WIDTH-1:0] res_full;

  assign accept   = (state_q == S_IDLE) && START;
  assign last_bit = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (START) state_d = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-bit slice; operands are shifted right so bit 0 is always current
  assign is_add      = (mode_q == MODE_ADD);
  assign is_sub      = (mode_q == MODE_SUB);
  assign is_arith    = is_add | is_sub;
  assign is_reserved = mode_q[2] & mode_q[1];

  assign a_bit    = a_q[0];
  assign b_bit    = b_q[0] ^ is_sub;
  assign sum_bit  = a_bit ^ b_bit ^ carry_q;
  assign carry_nx = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));

  always_comb begin
    r_bit = 1'b0;
    unique case (mode_q)
      MODE_ADD, MODE_SUB: r_bit = sum_bit;
      MODE_AND:           r_bit = a_q[0] & b_q[0];
      MODE_OR:            r_bit = a_q[0] | b_q[0];
      MODE_XOR:           r_bit = a_q[0] ^ b_q[0];
      MODE_XNOR:          r_bit = ~(a_q[0] ^ b_q[0]);
      default:            r_bit = 1'b0;
    endcase
  end

  assign res_full = {r_bit, shift_q[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      X       <= '0;
      C_out   <= 1'b0;
      ZERO    <= 1'b0;
      OVF     <= 1'b0;
      ERR     <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= A;
      b_q     <= B;
      mode_q  <= Mode;
      shift_q <= '0;
      // SUB is A + ~B + ~borrow, so the borrow-in enters inverted
      if (Mode == MODE_ADD)      carry_q <= C_in;
      else if (Mode == MODE_SUB) carry_q <= ~C_in;
      else                       carry_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      shift_q <= res_full;
      if (is_arith) carry_q <= carry_nx;
      if (last_bit) begin
        X     <= res_full;
        C_out <= is_arith & carry_nx;
        OVF   <= is_arith & (carry_q ^ carry_nx);
        ZERO  <= (res_full == '0);
        ERR   <= is_reserved;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=8): latency, handshake,
// flags, reserved modes and mid-run reset.

module tb_serial_alu;

  localparam int WIDTH = 8;

  logic             CLK, RST_N, START, C_in;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] A, B;
  logic             READY, BUSY, DONE, C_out, ZERO, OVF, ERR;
  logic [WIDTH-1:0] X;

  int passed = 0;
  int total  = 0;

  serial_alu #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .Mode(Mode), .A(A), .B(B),
    .C_in(C_in), .READY(READY), .BUSY(BUSY), .DONE(DONE), .X(X),
    .C_out(C_out), .ZERO(ZERO), .OVF(OVF), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One operation from IDLE; optionally scrambles the inputs mid-run.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input bit disturb,
                        input logic [7:0] ex, input logic ec, input logic ez,
                        input logic eo, input logic ee);
    logic [7:0] prev_x;
    bit busy_ok, hold_ok;
    @(negedge CLK);
    chk({tag, "_ready"}, READY, 1);
    prev_x = X;
    Mode = m; A = a; B = b; C_in = cin; START = 1'b1;
    @(posedge CLK);
    busy_ok = 1; hold_ok = 1;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge CLK);
      if (i == 0) START = 1'b0;
      if (disturb && i == 2) begin
        A = 8'hFF; B = 8'hFF; Mode = 3'b101; C_in = 1'b1;
      end
      if (!(BUSY === 1'b1 && DONE === 1'b0 && READY === 1'b0)) busy_ok = 0;
      if (X !== prev_x) hold_ok = 0;
      @(posedge CLK);
    end
    chk({tag, "_busy"}, busy_ok, 1);
    chk({tag, "_hold"}, hold_ok, 1);
    @(negedge CLK);
    chk({tag, "_done"}, {DONE, BUSY}, 2'b10);
    chk({tag, "_x"}, X, ex);
    chk({tag, "_flags"}, {C_out, ZERO, OVF, ERR}, {ec, ez, eo, ee});
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_idle"}, {READY, DONE}, 2'b10);
  endtask

  int done_cnt, first_done, second_done;
  bit x_ok;

  initial begin
    RST_N = 1'b0; START = 1'b0; Mode = 3'b000; A = '0; B = '0; C_in = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_hs", {READY, BUSY, DONE}, 3'b100);
    chk("rst_out", {X, C_out, ZERO, OVF, ERR}, 12'h000);
    RST_N = 1'b1;

    //      tag          mode    A      B      cin dist  X      C  Z  O  E
    run_op("add_ovf",   3'b000, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 0, 1, 0);
    run_op("sub_eq",    3'b101, 8'h05, 8'h05, 0, 0, 8'h00, 1, 1, 0, 0);
    run_op("sub_borrow",3'b101, 8'h00, 8'h01, 0, 0, 8'hFF, 0, 0, 0, 0);
    run_op("xnor",      3'b100, 8'hF0, 8'h3C, 0, 0, 8'h33, 0, 0, 0, 0);
    run_op("and_cin",   3'b001, 8'hF0, 8'h3C, 1, 0, 8'h30, 0, 0, 0, 0);
    run_op("add_cin",   3'b000, 8'hFF, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);
    run_op("sub_ovf",   3'b101, 8'h80, 8'h01, 0, 0, 8'h7F, 1, 0, 1, 0);
    run_op("xor",       3'b011, 8'hA5, 8'h0F, 0, 0, 8'hAA, 0, 0, 0, 0);

    // START held for 20 cycles: accepts at edges 1 and 11 only
    @(negedge CLK);
    Mode = 3'b000; A = 8'h01; B = 8'h01; C_in = 1'b0; START = 1'b1;
    done_cnt = 0; first_done = -1; second_done = -1; x_ok = 1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (i == 20) START = 1'b0;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) first_done = i;
        if (done_cnt == 2) second_done = i;
        if (X !== 8'h02) x_ok = 0;
      end
    end
    chk("b2b_count", done_cnt, 2);
    chk("b2b_first", first_done, 9);
    chk("b2b_spacing", second_done - first_done, WIDTH + 2);
    chk("b2b_x", x_ok, 1);

    run_op("add_disturb", 3'b000, 8'h01, 8'h01, 0, 1, 8'h02, 0, 0, 0, 0);

    // Reset after three bits have been computed
    @(negedge CLK);
    Mode = 3'b000; A = 8'h0F; B = 8'h01; C_in = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_hs", {READY, BUSY, DONE}, 3'b100);
    chk("midrst_out", {X, C_out, ZERO, OVF, ERR}, 12'h000);
    done_cnt = 0;
    repeat (2) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_cnt++;
    end
    @(posedge CLK);
    #2 RST_N = 1'b1;
    chk("midrst_nodone", done_cnt, 0);

    run_op("reserved", 3'b110, 8'hAB, 8'hCD, 1, 0, 8'h00, 0, 1, 0, 1);
    run_op("or_clr",   3'b010, 8'h0F, 8'hF0, 0, 0, 8'hFF, 0, 0, 0, 0);
    run_op("rsv111",   3'b111, 8'h55, 8'h55, 0, 0, 8'h00, 0, 1, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Parametrised, bit-serial successor to the single-bit ALU slice.
- Latches WIDTH-bit operands and a mode, then computes one bit per clock, LSB first, through a single internal slice.
- Returns a full-width result with flags under a start/busy/done handshake.
- Used where area matters more than latency; sits between the operand registers and the result bus.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only when READY=1
Mode  input  3  operation select, latched on accepted START
A  input  WIDTH  operand A, latched on accepted START
B  input  WIDTH  operand B, latched on accepted START
C_in  input  1  carry-in (ADD) / borrow-in (SUB), latched on accepted START
READY  output  1  high in IDLE only
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse when result is valid
X  output  WIDTH  result register
C_out  output  1  carry-out (ADD/SUB only, else 0)
ZERO  output  1  X == 0
OVF  output  1  signed overflow (ADD/SUB only, else 0)
ERR  output  1  reserved mode executed

Behaviour:
- Modes:
  - 000 ADD: A+B+C_in.
  - 001 AND.
  - 010 OR.
  - 011 XOR.
  - 100 XNOR.
  - 101 SUB: A+~B+~C_in, i.e. A-B-C_in.
  - 110/111: reserved.
- Reset (async, RST_N=0): state=IDLE; X=0; C_out=0; ZERO=0; OVF=0; ERR=0; BUSY=0; DONE=0; READY=1. The counter, operand and carry registers are cleared.
- FSM states:
  - IDLE: READY=1. START=1 at edge k latches A, B, Mode and C_in. The carry register is initialised to C_in (ADD), ~C_in (SUB) or 0 (logic modes). Go to RUN; counter=0.
  - RUN: BUSY=1. At each edge, compute bit[counter] from A[counter], B[counter] (inverted for SUB) and the carry; shift it into the internal result shift register; update carry (ADD/SUB only); increment counter. After bit WIDTH-1 (edge k+WIDTH), load the output registers and go to DONE.
  - DONE: lasts exactly one cycle (cycle after edge k+WIDTH); DONE=1; then go to IDLE.
- Latency: START sampled at edge k produces DONE=1 in the cycle following edge k+WIDTH. Next START can be accepted at edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Output registers:
  - X, C_out, ZERO, OVF and ERR are loaded only at the completion edge.
  - They hold through the following operation until its completion edge; they do not change during RUN.
- Flags:
  - C_out = final carry (ADD/SUB); for SUB, 1 means no borrow.
  - OVF = carry into MSB XOR carry out of MSB (ADD/SUB).
  - ZERO evaluated on the loaded X.
  - Reserved modes: X=0, C_out=0, OVF=0, ZERO=1, ERR=1.
  - Any valid mode clears ERR.
- START while BUSY or DONE: ignored. No queuing, no latching, no effect on the in-flight operation.
- Operand inputs may change freely after the accepting edge.
- RST_N asserted mid-RUN: operation aborted immediately, all outputs at reset values, no DONE pulse. START at the first edge after deassertion is accepted.
- Counter terminates at WIDTH-1; no wrap into a second pass.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles -> READY=1, BUSY=0, DONE=0, X=0x00, all flags 0.
- ADD, WIDTH=8: A=0x7F, B=0x01, C_in=0, START at edge k -> DONE=1 only in the cycle after edge k+8, BUSY=1 for 8 cycles; X=0x80, C_out=0, OVF=1, ZERO=0.
- SUB: A=0x05, B=0x05, C_in=0 -> X=0x00, C_out=1, ZERO=1, OVF=0. Then A=0x00, B=0x01, C_in=0 -> X=0xFF, C_out=0.
- Logic: XNOR A=0xF0, B=0x3C -> X=0x33, C_out=0, OVF=0; AND with C_in=1 -> X=0x30, C_out=0 (C_in ignored).
- Handshake: START held high for 20 cycles with ADD 0x01+0x01 -> back-to-back results 0x02 at DONE pulses spaced exactly WIDTH+2 cycles. A changed to 0xFF mid-RUN does not affect the in-flight result.
- Reset mid-RUN at bit 3, then reserved Mode=110 -> no DONE pulse, outputs cleared; next op gives X=0x00, ZERO=1, ERR=1. A following OR 0x0F|0xF0 gives X=0xFF, ERR=0.
